// File: rtl/riscv_pkg.sv
// Shared decode/execute definitions: ALU opcodes, default widths and the
// ID/EX payload carried from decode to the ALU.
package riscv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RW   = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  // Source register addresses are kept outside the payload: they only matter
  // when forwarding is built in.
  typedef struct packed {
    logic [DEF_XLEN-1:0] rs1_data;
    logic [DEF_XLEN-1:0] rs2_data;
    logic [DEF_XLEN-1:0] imm;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_RW-1:0]   rd_addr;
    logic                alu_src;
    logic [2:0]          alu_control;
    logic                reg_write;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forward select: EX/MEM result beats MEM/WB result beats held data.
// Register x0 never matches a forward source.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic [RW-1:0]   src_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [RW-1:0]   exmem_rd_i,
  input  logic            exmem_we_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic            wb_we_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic [XLEN-1:0] fwd_data_o
);

  logic exmem_hit;
  logic wb_hit;

  assign exmem_hit = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i);
  assign wb_hit    = wb_we_i && (wb_rd_i != '0) && (wb_rd_i == src_addr_i);

  always_comb begin
    fwd_data_o = reg_data_i;
    if (exmem_hit) begin
      fwd_data_o = exmem_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU with valid/ready, flush and stall.
// Define ID_EX_FORWARDING_EN to add EX/MEM + MEM/WB forwarding and stall refresh.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RW   = DEF_RW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc_in,
  input  logic [RW-1:0]   rs1_addr,
  input  logic [RW-1:0]   rs2_addr,
  input  logic [RW-1:0]   rd_addr_in,
  input  logic            alu_src,
  input  logic [2:0]      alu_control_in,
  input  logic            reg_write_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  output logic [XLEN-1:0] store_data,
  output logic [RW-1:0]   rd_addr,
  output logic            reg_write,
  output logic [XLEN-1:0] pc_out
`ifdef ID_EX_FORWARDING_EN
  ,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_we,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RW-1:0]   wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_result
`endif
);

  logic      valid_q, valid_d;
  id_ex_t    payload_q, payload_d;
  logic      accept;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef ID_EX_FORWARDING_EN
  logic [RW-1:0] rs1_addr_q, rs1_addr_d;
  logic [RW-1:0] rs2_addr_q, rs2_addr_d;
  logic          refresh;

  // Held operands absorb results retiring while downstream is stalled.
  assign refresh = valid_q && !out_ready && !flush;

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
    .src_addr_i     (rs1_addr_q),
    .reg_data_i     (payload_q.rs1_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_we),
    .exmem_result_i (exmem_result),
    .wb_rd_i        (wb_rd),
    .wb_we_i        (wb_we),
    .wb_result_i    (wb_result),
    .fwd_data_o     (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
    .src_addr_i     (rs2_addr_q),
    .reg_data_i     (payload_q.rs2_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_we),
    .exmem_result_i (exmem_result),
    .wb_rd_i        (wb_rd),
    .wb_we_i        (wb_we),
    .wb_result_i    (wb_result),
    .fwd_data_o     (rs2_fwd)
  );

  always_comb begin
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    if (accept) begin
      rs1_addr_d = rs1_addr;
      rs2_addr_d = rs2_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else begin
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
    end
  end
`else
  logic unused_src_addr;

  // Without forwarding the hazard unit stalls decode on every RAW dependency.
  assign unused_src_addr = ^{rs1_addr, rs2_addr};
  assign rs1_fwd = payload_q.rs1_data;
  assign rs2_fwd = payload_q.rs2_data;
`endif

  // Flush wins over everything; payload is left stale on flush.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d               = 1'b1;
      payload_d.rs1_data    = rs1_data;
      payload_d.rs2_data    = rs2_data;
      payload_d.imm         = imm;
      payload_d.pc          = pc_in;
      payload_d.rd_addr     = rd_addr_in;
      payload_d.alu_src     = alu_src;
      payload_d.alu_control = alu_control_in;
      payload_d.reg_write   = reg_write_in;
    end else begin
      if (out_ready) begin
        valid_d = 1'b0;
      end
`ifdef ID_EX_FORWARDING_EN
      if (refresh) begin
        payload_d.rs1_data = rs1_fwd;
        payload_d.rs2_data = rs2_fwd;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q               <= 1'b0;
      payload_q             <= '0;
      payload_q.alu_control <= ALU_ADD;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = rs1_fwd;
  assign alu_b       = payload_q.alu_src ? payload_q.imm : rs2_fwd;
  assign store_data  = rs2_fwd;
  assign alu_control = payload_q.alu_control;
  assign rd_addr     = payload_q.rd_addr;
  assign reg_write   = payload_q.reg_write;
  assign pc_out      = payload_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus a randomized
// scoreboard run against a one-entry pipeline-register reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] rs1_data, rs2_data, imm, pc_in;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in;
  logic        alu_src;
  logic [2:0]  alu_control_in;
  logic        reg_write_in;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, store_data, pc_out;
  logic [2:0]  alu_control;
  logic [4:0]  rd_addr;
  logic        reg_write;
`ifdef ID_EX_FORWARDING_EN
  logic [4:0]  exmem_rd, wb_rd;
  logic        exmem_we, wb_we;
  logic [31:0] exmem_result, wb_result;
`endif

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr_in(rd_addr_in),
    .alu_src(alu_src), .alu_control_in(alu_control_in), .reg_write_in(reg_write_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write), .pc_out(pc_out)
`ifdef ID_EX_FORWARDING_EN
    ,
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b, sd, pc;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  ctl;
  } exp_t;

  exp_t exp_q[$];
  logic exp_valid = 1'b0;
  logic exp_valid_nxt = 1'b0;
  logic scb_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic src, input logic [2:0] ctl,
                          input logic we);
    rs1_data = r1; rs2_data = r2; imm = im; pc_in = pc;
    rs1_addr = a1; rs2_addr = a2; rd_addr_in = rd;
    alu_src = src; alu_control_in = ctl; reg_write_in = we;
  endtask

  // Monitor: compares handshaken outputs against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb_on) begin
        chk("scb_out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        chk("scb_in_ready", {31'b0, in_ready}, {31'b0, (!exp_valid || out_ready)});
        if (out_valid && out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scb_underflow: got out_valid=1 required no pending beat at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("scb_alu_a", alu_a, e.a);
            chk("scb_alu_b", alu_b, e.b);
            chk("scb_store_data", store_data, e.sd);
            chk("scb_pc_out", pc_out, e.pc);
            chk("scb_rd_addr", {27'b0, rd_addr}, {27'b0, e.rd});
            chk("scb_reg_write", {31'b0, reg_write}, {31'b0, e.we});
            chk("scb_alu_control", {29'b0, alu_control}, {29'b0, e.ctl});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
`ifdef ID_EX_FORWARDING_EN
    exmem_rd = 0; exmem_we = 0; exmem_result = 0;
    wb_rd = 0; wb_we = 0; wb_result = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_control", {29'b0, alu_control}, 32'd0);
    chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    reset = 1'b0;

    // Basic accept
    set_beat(32'd5, 32'd7, 32'h0, 32'h10, 5'd1, 5'd2, 5'd3, 1'b0, 3'b010, 1'b1);
    in_valid = 1'b1;
    #1 chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    tick;
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    chk("t1_alu_control", {29'b0, alu_control}, 32'd2);
    chk("t1_pc_out", pc_out, 32'h10);

    // Back-pressure for three cycles with a second beat offered
    out_ready = 1'b0;
    set_beat(32'd9, 32'd11, 32'h100, 32'h40, 5'd1, 5'd2, 5'd6, 1'b1, 3'b100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_in_ready_stall", {31'b0, in_ready}, 32'd0);
      chk("t2_held_alu_a", alu_a, 32'd5);
      chk("t2_held_alu_b", alu_b, 32'd7);
      tick;
    end
    out_ready = 1'b1;
    #1 chk("t2_in_ready_release", {31'b0, in_ready}, 32'd1);
    chk("t2_release_alu_a", alu_a, 32'd5);
    tick;
    in_valid = 1'b0;
    chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_alu_a", alu_a, 32'd9);
    chk("t2_alu_b_imm", alu_b, 32'h100);
    chk("t2_store_data", store_data, 32'd11);
    chk("t2_alu_control", {29'b0, alu_control}, 32'd4);
    chk("t2_rd_addr", {27'b0, rd_addr}, 32'd6);
    chk("t2_reg_write", {31'b0, reg_write}, 32'd1);
    tick;
    chk("t2_drained", {31'b0, out_valid}, 32'd0);

    // Flush drops both the held and the incoming beat
    set_beat(32'h11, 32'h12, 32'h0, 32'h80, 5'd1, 5'd2, 5'd7, 1'b0, 3'b110, 1'b1);
    in_valid = 1'b1;
    tick;
    chk("t3_loaded", {31'b0, out_valid}, 32'd1);
    set_beat(32'h22, 32'h23, 32'h0, 32'h99, 5'd1, 5'd2, 5'd8, 1'b0, 3'b111, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_flush_valid", {31'b0, out_valid}, 32'd0);
    tick;
    chk("t3_flush_valid_later", {31'b0, out_valid}, 32'd0);
    chk("t3_dropped_alu_a", alu_a, 32'h11);
    chk("t3_dropped_pc", pc_out, 32'h80);

    // Asynchronous reset in the middle of a stall
    set_beat(32'h33, 32'h44, 32'h0, 32'hC0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b111, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    chk("t4_stalled_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_stalled_ctl", {29'b0, alu_control}, 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_async_ctl", {29'b0, alu_control}, 32'd0);
    chk("t4_async_reg_write", {31'b0, reg_write}, 32'd0);
    chk("t4_async_alu_a", alu_a, 32'd0);
    tick;
    reset = 1'b0; out_ready = 1'b1;

`ifdef ID_EX_FORWARDING_EN
    // Forward priority on rs1
    set_beat(32'h10, 32'h20, 32'h0, 32'h0, 5'd3, 5'd4, 5'd1, 1'b0, 3'b000, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    exmem_we = 1; exmem_rd = 3; exmem_result = 32'hAA;
    wb_we = 1; wb_rd = 3; wb_result = 32'hBB;
    #1 chk("f_exmem_prio", alu_a, 32'hAA);
    exmem_rd = 0;
    #1 chk("f_wb_second", alu_a, 32'hBB);
    exmem_we = 0; wb_we = 0;
    tick;
    // x0 is never forwarded
    set_beat(32'h77, 32'h20, 32'h0, 32'h0, 5'd0, 5'd4, 5'd1, 1'b0, 3'b000, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    exmem_we = 1; exmem_rd = 0; exmem_result = 32'hAA;
    wb_we = 1; wb_rd = 0; wb_result = 32'hBB;
    #1 chk("f_x0_no_fwd", alu_a, 32'h77);
    exmem_we = 0; wb_we = 0;
    tick;
    // Stall refresh keeps a result that retired from WB
    set_beat(32'h5, 32'h1, 32'h0, 32'h0, 5'd7, 5'd4, 5'd2, 1'b0, 3'b000, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    wb_we = 1; wb_rd = 4; wb_result = 32'h55;
    #1 chk("f_wb_store", store_data, 32'h55);
    chk("f_wb_alu_b", alu_b, 32'h55);
    tick;
    wb_we = 0; wb_result = 0;
    #1 chk("f_refresh_held", store_data, 32'h55);
    out_ready = 1'b1;
    #1 chk("f_refresh_release", store_data, 32'h55);
    tick;
    chk("f_refresh_drained", {31'b0, out_valid}, 32'd0);
`endif

    // Randomized scoreboard phase
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    exp_valid_nxt = 1'b0;
    scb_on = 1'b1;
    for (int i = 0; i < 420; i++) begin
      tick;
      exp_valid = exp_valid_nxt;
      set_beat($urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (i < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 15) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      if (flush) begin
        if (exp_valid && exp_q.size() != 0) void'(exp_q.pop_front());
        exp_valid_nxt = 1'b0;
      end else begin
        acc = in_valid && (!exp_valid || out_ready);
        if (acc) begin
          e.a   = rs1_data;
          e.b   = alu_src ? imm : rs2_data;
          e.sd  = rs2_data;
          e.pc  = pc_in;
          e.rd  = rd_addr_in;
          e.we  = reg_write_in;
          e.ctl = alu_control_in;
          exp_q.push_back(e);
          exp_valid_nxt = 1'b1;
        end else if (exp_valid && out_ready) begin
          exp_valid_nxt = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1;
    scb_on = 1'b0;
    chk("scb_queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that feeds the ALU. It holds one decoded instruction and presents `A`, `B` and `ALUControl` to the ALU. When operand forwarding is compiled in, it substitutes in-flight results from the EX/MEM and MEM/WB stages. It uses a valid/ready handshake on both sides, supports flush (branch redirect) and stall (downstream back-pressure), and keeps held operands current while stalled.

## Interface
- Parameters:
- `XLEN`, 32, datapath width
- `RW`, 5, register-address width
- Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high reset
- `in_valid` in 1: decode offers an instruction
- `in_ready` out 1: stage can accept
- `rs1_data`, `rs2_data` in XLEN: register-file read data
- `imm` in XLEN: sign-extended immediate
- `pc_in` in XLEN: instruction PC
- `rs1_addr`, `rs2_addr`, `rd_addr_in` in RW: register specifiers
- `alu_src` in 1: 1 selects `imm` for B, 0 selects rs2
- `alu_control_in` in 3: ALU opcode
- `reg_write_in` in 1: instruction writes rd
- `flush` in 1: discard held and incoming instruction
- `out_valid` out 1: held instruction valid
- `out_ready` in 1: execute/memory side accepts
- `alu_a`, `alu_b` out XLEN: ALU operands
- `alu_control` out 3: ALU opcode
- `store_data` out XLEN: forwarded rs2 value
- `rd_addr` out RW; `reg_write` out 1; `pc_out` out XLEN
- `exmem_rd` in RW, `exmem_we` in 1, `exmem_result` in XLEN: EX/MEM forward source (present only with the macro)
- `wb_rd` in RW, `wb_we` in 1, `wb_result` in XLEN: MEM/WB forward source (present only with the macro)

## Operation
- `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
- Accept: when `in_valid && in_ready && !flush`, capture all fields. `out_valid` is 1 the next cycle.
- Consume without a new accept: when `out_valid && out_ready`, `out_valid` is 0 the next cycle.
- Flush has the highest priority:
  - `out_valid` is 0 the next cycle.
  - A beat that handshakes in the same cycle is dropped.
  - Payload registers keep their stale values.
- `alu_b = alu_src ? imm_q : rs2_fwd`. `alu_a = rs1_fwd`. `store_data = rs2_fwd`.
- Forward select for each of rs1 and rs2 (combinational, on the held values):
  - Priority 1: EX/MEM when `exmem_we` is set, `exmem_rd` is nonzero and `exmem_rd` matches the source address.
  - Priority 2: WB under the same conditions on `wb_we` / `wb_rd`.
  - Otherwise: the held register data.
- Register x0 is never forwarded.
- Stall refresh: while `out_valid && !out_ready && !flush`, `rs1_q` and `rs2_q` are overwritten each cycle with `rs1_fwd` and `rs2_fwd`. A result that retires from WB during a stall is therefore not lost.
- `alu_control` passes the ALU opcode through unchanged. Opcode 011 is legal to carry, and the ALU returns 0 for it.

## Timing
- Reset values: `out_valid` 0; all payload registers 0 (`alu_control` 3'b000 = add, `reg_write` 0). `in_ready` is 1 after reset.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- Forwarding muxes are combinational and add no cycle.
- If reset is asserted mid-stall, all state clears immediately. No instruction survives.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- Defined:
  - Forward ports exist.
  - Forwarding and stall refresh behave as above.
- Undefined:
  - Forward ports are omitted.
  - `rs1_fwd = rs1_q` and `rs2_fwd = rs2_q`.
  - No refresh. The hazard unit must stall decode for all RAW dependencies.

## Structure
- Shared `riscv_pkg`:
  - ALU opcode constants: ADD 000, SLL 001, SUB 010, XOR 100, SRL 101, OR 110, AND 111.
  - `id_ex_t` payload struct.
  - `XLEN` / `RW` defaults.
- Sub-module `fwd_mux`: address compare plus priority select, instantiated twice (rs1, rs2).

## Test plan
- Reset, then `in_valid`=1 with `rs1_data`=5, `rs2_data`=7, `alu_src`=0, `alu_control_in`=010:
  - Next cycle: `out_valid`=1, `alu_a`=5, `alu_b`=7, `alu_control`=010.
- `out_ready`=0 for 3 cycles while a second beat is offered:
  - `in_ready`=0 throughout.
  - First instruction held unchanged.
  - Second instruction accepted on the cycle after `out_ready` rises.
- Held `rs1_addr`=3:
  - `exmem_rd`=3 with result 0xAA and `wb_rd`=3 with result 0xBB: `alu_a`=0xAA.
  - `exmem_rd`=0: `alu_a`=0xBB.
  - `rs1_addr`=0 with both sources matching rd 0: `alu_a` stays the register value.
- Stalled instruction with `rs2_addr`=4 and `wb_rd`=4 carrying 0x55 for one cycle, then WB idle:
  - `store_data` stays 0x55 after release.
- `flush`=1 together with `in_valid`=1 and `out_valid`=1:
  - Next cycle `out_valid`=0.
  - The dropped instruction never appears.
- Assert `reset` asynchronously mid-stall:
  - `out_valid` falls without waiting for a clock edge.
  - `alu_control`=000, `reg_write`=0.
